// File: rtl/data_memory_ctrl.sv
// Data memory with a valid/ready request port and a fixed-latency response port.
// Little-endian byte/half/word(/double) access with lane writes and load extension.
module data_memory_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;
    typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

    // Power-up contents: word i holds the value i; reset leaves the array alone.
    function automatic mem_t f_mem_init();
        mem_t v_m;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            v_m[i] = DATA_W'(i);
        end
        return v_m;
    endfunction

    mem_t r_mem = f_mem_init();

    state_e             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               r_pend_valid;
    logic [DATA_W-1:0]  r_pend_rdata;
    logic               r_pend_err;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_rsp_err;

    logic [OFF_W-1:0]   w_offset;
    logic [ADDR_W-1:0]  w_idx_full;
    logic [IDX_W-1:0]   w_idx;
    logic [OFF_W+2:0]   w_shamt;
    logic [3:0]         w_nbytes;
    logic [6:0]         w_nbits;
    logic [OFF_W-1:0]   w_align_mask;
    logic               w_err;
    logic               w_accept;
    logic               w_do_write;
    logic               w_emit;
    logic [DATA_W-1:0]  w_shifted;
    logic [DATA_W-1:0]  w_load;
    logic [DATA_W-1:0]  w_rdata_res;
    logic [DATA_W-1:0]  w_wdata_sh;
    logic [NB-1:0]      w_be;
    logic               w_sign;

    assign w_offset     = i_req_addr[OFF_W-1:0];
    assign w_idx_full   = i_req_addr >> OFF_W;
    assign w_idx        = w_idx_full[IDX_W-1:0];
    assign w_shamt      = {w_offset, 3'b000};
    assign w_nbytes     = 4'd1 << i_req_size;
    assign w_nbits      = 7'd8 << i_req_size;
    assign w_align_mask = OFF_W'(w_nbytes - 4'd1);

    // Out-of-range also catches any nonzero address bit above the index field.
    assign w_err = (|(w_offset & w_align_mask))
                 | (w_idx_full >= ADDR_W'(DEPTH))
                 | ((i_req_size == 2'b11) && (DATA_W == 32));

    assign o_req_ready = (r_state == StIdle);
    assign w_accept    = i_req_valid & o_req_ready;
    assign w_do_write  = w_accept & i_rst_n & i_req_we & ~w_err;
    assign w_emit      = r_pend_valid & (r_state == StIdle);
    assign w_shifted   = r_mem[w_idx] >> w_shamt;
    assign w_wdata_sh  = i_req_wdata << w_shamt;

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

    // Extract the addressed bytes to bit 0 and extend above the access width.
    always_comb begin
        w_load = w_shifted;
        case (i_req_size)
            2'b00:   w_sign = w_shifted[7];
            2'b01:   w_sign = w_shifted[15];
            default: w_sign = w_shifted[31];
        endcase
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (i >= 32'(w_nbits)) begin
                w_load[i] = i_req_unsigned ? 1'b0 : w_sign;
            end
        end
        w_rdata_res = (w_err || i_req_we) ? '0 : w_load;
    end

    // Byte lanes touched by the access.
    always_comb begin
        w_be = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            w_be[b] = (b >= 32'(w_offset)) && (b < 32'(w_offset) + 32'(w_nbytes));
        end
    end

    // Store commit on the accepting edge; untouched lanes keep their contents.
    always_ff @(posedge i_clk) begin
        if (w_do_write) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
                end
            end
        end
    end

    // Next-state logic: WAIT holds off new requests until the counter expires.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            StIdle: begin
                if (w_accept && (RD_LAT > 1)) begin
                    w_state_next = StWait;
                    w_cnt_next   = CNT_W'(RD_LAT - 1);
                end
            end
            StWait: begin
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State, pending result and registered response port.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_rdata <= '0;
            r_pend_err   <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_rsp_valid <= w_emit;
            if (w_emit) begin
                r_rsp_rdata <= r_pend_rdata;
                r_rsp_err   <= r_pend_err;
            end
            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_rdata <= w_rdata_res;
                r_pend_err   <= w_err;
            end else if (w_emit) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

endmodule
